// File: rtl/dp_types_pkg.sv
// Shared datapath types for the branch predictor: PC decode, 2-bit counter
// state and the BTB entry layout.
package dp_types_pkg;
  localparam int BTAG_W      = 22;
  localparam int BIND_W      = 8;
  localparam int BBYT_W      = 2;
  localparam int BTB_ENTRIES = 1 << BIND_W;

  typedef enum logic [1:0] {
    NH = 2'b00,
    NS = 2'b01,
    TH = 2'b10,
    TS = 2'b11
  } branch_pred_state_t;

  typedef struct packed {
    logic [BTAG_W-1:0] tag;
    logic [BIND_W-1:0] ind;
    logic [BBYT_W-1:0] offs;
  } branch_pred_instr_t;

  typedef struct packed {
    branch_pred_state_t state;
    logic [31:0]        target;
  } branch_pred_frame_t;

  typedef struct packed {
    logic               valid;
    logic [BTAG_W-1:0]  tag;
    branch_pred_frame_t frame;
  } btb_entry_t;
endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch lookup, MEM-stage update and statistics signals of the BTB.
interface branch_target_buffer_if;
  logic [31:0] lkp_pc;
  logic        lkp_hit;
  logic        lkp_taken;
  logic [31:0] lkp_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  modport master (
    output lkp_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken,
    input  lkp_hit, lkp_taken, lkp_target, stat_branches, stat_mispred
  );
  modport slave (
    input  lkp_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken,
    output lkp_hit, lkp_taken, lkp_target, stat_branches, stat_mispred
  );
endinterface

// File: rtl/branch_target_buffer_state_next.sv
// 2-bit saturating counter step: taken moves toward TS, not-taken toward NH.
module bpred_state_next
  import dp_types_pkg::*;
(
  input  branch_pred_state_t state,
  input  logic               taken,
  output branch_pred_state_t next_state
);
  always_comb begin
    next_state = state;
    if (taken) begin
      case (state)
        NH:      next_state = NS;
        NS:      next_state = TH;
        default: next_state = TS;
      endcase
    end else begin
      case (state)
        TS:      next_state = TH;
        TH:      next_state = NS;
        default: next_state = NH;
      endcase
    end
  end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit predictors: combinational fetch lookup,
// registered update from MEM, saturating branch/mispredict statistics.
module branch_target_buffer
  import dp_types_pkg::*;
#(
  parameter logic [31:0] STAT_RST_VAL = 32'h0
) (
  input logic                    CLK,
  input logic                    RST,
  branch_target_buffer_if.slave  bus
);
  logic               valid_q  [BTB_ENTRIES];
  branch_pred_state_t state_q  [BTB_ENTRIES];
  logic [BTAG_W-1:0]  tag_q    [BTB_ENTRIES];
  logic [31:0]        target_q [BTB_ENTRIES];
  logic [31:0]        br_q, mp_q;

  branch_pred_instr_t li, ui;
  btb_entry_t         lkp_e;
  branch_pred_state_t st_nxt;
  logic               accept, uhit;

  assign li = bus.lkp_pc;
  assign ui = bus.upd_pc;

  always_comb begin
    lkp_e.valid        = valid_q[li.ind];
    lkp_e.tag          = tag_q[li.ind];
    lkp_e.frame.state  = state_q[li.ind];
    lkp_e.frame.target = target_q[li.ind];
  end

  // Reads see the pre-edge array, so a same-cycle update is not bypassed.
  assign bus.lkp_hit    = lkp_e.valid && (lkp_e.tag == li.tag) && (li.offs == '0);
  assign bus.lkp_taken  = bus.lkp_hit && lkp_e.frame.state[1];
  assign bus.lkp_target = bus.lkp_taken ? lkp_e.frame.target : bus.lkp_pc + 32'd4;

  assign accept = bus.upd_en && (ui.offs == '0);
  assign uhit   = valid_q[ui.ind] && (tag_q[ui.ind] == ui.tag);

  bpred_state_next u_next (
    .state      (state_q[ui.ind]),
    .taken      (bus.upd_taken),
    .next_state (st_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        state_q[i] <= NH;
      end
      br_q <= STAT_RST_VAL;
      mp_q <= STAT_RST_VAL;
    end else if (accept) begin
      br_q <= (br_q == '1) ? br_q : br_q + 32'd1;
      if (bus.upd_taken != bus.upd_pred_taken)
        mp_q <= (mp_q == '1) ? mp_q : mp_q + 32'd1;
      if (uhit) begin
        state_q[ui.ind] <= st_nxt;
      end else if (bus.upd_taken) begin
        valid_q[ui.ind] <= 1'b1;
        state_q[ui.ind] <= TH;
      end
    end
  end

  // Tag/target carry no reset; the valid bit qualifies them.
  always_ff @(posedge CLK) begin
    if (!RST && accept && bus.upd_taken) begin
      target_q[ui.ind] <= bus.upd_target;
      if (!uhit) tag_q[ui.ind] <= ui.tag;
    end
  end

  assign bus.stat_branches = br_q;
  assign bus.stat_mispred  = mp_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer and bpred_state_next.
module tb_branch_target_buffer;
  import dp_types_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_target_buffer_if bus ();
  branch_target_buffer_if bus2 ();

  branch_target_buffer dut (.CLK(clk), .RST(rst), .bus(bus));
  branch_target_buffer #(.STAT_RST_VAL(32'hFFFF_FFFD)) dut_sat (.CLK(clk), .RST(rst), .bus(bus2));

  branch_pred_state_t bsn_in, bsn_out;
  logic               bsn_taken;
  bpred_state_next u_bsn (.state(bsn_in), .taken(bsn_taken), .next_state(bsn_out));

  int n_chk = 0, n_fail = 0;

  // Reference model: plain arrays and integer counters.
  bit          m_valid [256];
  logic [21:0] m_tag   [256];
  int          m_state [256];
  logic [31:0] m_tgt   [256];
  longint      m_br, m_mp;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 0;
      m_state[i] = 0;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic void model_update(logic [31:0] pc, logic tk, logic [31:0] tg, logic pr);
    int idx;
    if (pc % 4 != 0) return;
    idx = int'((pc / 4) % 256);
    if (m_br < 64'hFFFF_FFFF) m_br++;
    if (tk != pr && m_mp < 64'hFFFF_FFFF) m_mp++;
    if (m_valid[idx] && m_tag[idx] == pc[31:10]) begin
      m_state[idx] = tk ? ((m_state[idx] == 3) ? 3 : m_state[idx] + 1)
                        : ((m_state[idx] == 0) ? 0 : m_state[idx] - 1);
      if (tk) m_tgt[idx] = tg;
    end else if (tk) begin
      m_valid[idx] = 1;
      m_tag[idx]   = pc[31:10];
      m_state[idx] = 2;
      m_tgt[idx]   = tg;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic look_exp(input string nm, input logic [31:0] pc, input logic h,
                          input logic t, input logic [31:0] tg);
    bus.lkp_pc = pc;
    #1;
    chk({nm, ".hit"}, 32'(bus.lkp_hit), 32'(h));
    chk({nm, ".taken"}, 32'(bus.lkp_taken), 32'(t));
    chk({nm, ".target"}, bus.lkp_target, tg);
  endtask

  task automatic look_model(input string nm, input logic [31:0] pc);
    int idx;
    logic h, t;
    idx = int'((pc / 4) % 256);
    h = (pc % 4 == 0) && m_valid[idx] && (m_tag[idx] == pc[31:10]);
    t = h && (m_state[idx] >= 2);
    look_exp(nm, pc, h, t, t ? m_tgt[idx] : pc + 32'd4);
  endtask

  task automatic chk_stats(input string nm, input logic [31:0] br, input logic [31:0] mp);
    chk({nm, ".branches"}, bus.stat_branches, br);
    chk({nm, ".mispred"}, bus.stat_mispred, mp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic pr);
    bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_target = tg; bus.upd_pred_taken = pr;
    bus.upd_en = 1'b1;
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
    model_update(pc, tk, tg, pr);
  endtask

  typedef struct {
    branch_pred_state_t st;
    logic               tk;
    branch_pred_state_t exp;
  } bsn_vec_t;

  bsn_vec_t vecs [8];

  initial begin
    rst = 1'b1;
    bus.lkp_pc = '0; bus.upd_en = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_pred_taken = 1'b0;
    bus2.lkp_pc = '0; bus2.upd_en = 1'b0; bus2.upd_pc = 32'h80; bus2.upd_taken = 1'b1;
    bus2.upd_target = 32'h300; bus2.upd_pred_taken = 1'b0;

    vecs[0] = '{NH, 1'b0, NH}; vecs[1] = '{NH, 1'b1, NS};
    vecs[2] = '{NS, 1'b0, NH}; vecs[3] = '{NS, 1'b1, TH};
    vecs[4] = '{TH, 1'b0, NS}; vecs[5] = '{TH, 1'b1, TS};
    vecs[6] = '{TS, 1'b0, TH}; vecs[7] = '{TS, 1'b1, TS};
    for (int i = 0; i < 8; i++) begin
      bsn_in = vecs[i].st; bsn_taken = vecs[i].tk;
      #1;
      chk($sformatf("bsn[%0d]", i), 32'(bsn_out), 32'(vecs[i].exp));
    end

    @(negedge clk);
    do_reset();
    look_exp("reset", 32'h40, 1'b0, 1'b0, 32'h44);
    chk_stats("reset", 32'd0, 32'd0);

    // Saturating stats on the preloaded instance.
    chk("sat.init", bus2.stat_branches, 32'hFFFF_FFFD);
    for (int i = 1; i <= 4; i++) begin
      longint e;
      bus2.upd_en = 1'b1;
      @(posedge clk);
      #1;
      bus2.upd_en = 1'b0;
      e = 64'hFFFF_FFFD + i;
      if (e > 64'hFFFF_FFFF) e = 64'hFFFF_FFFF;
      chk($sformatf("sat.br[%0d]", i), bus2.stat_branches, 32'(e));
      chk($sformatf("sat.mp[%0d]", i), bus2.stat_mispred, 32'(e));
    end

    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look_exp("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    chk_stats("alloc", 32'd1, 32'd1);

    upd(32'h40, 1'b0, 32'h0, 1'b1);
    look_exp("walk.NS", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look_exp("walk.NH", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look_exp("walk.NS2", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look_exp("walk.TH", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look_exp("walk.TH-1", 32'h40, 1'b1, 1'b0, 32'h44);

    upd(32'h440, 1'b1, 32'h500, 1'b0);
    look_exp("alias.new", 32'h440, 1'b1, 1'b1, 32'h500);
    look_exp("alias.old", 32'h40, 1'b0, 1'b0, 32'h44);

    // Lookup during the allocating update sees the old contents.
    bus.upd_pc = 32'h80; bus.upd_taken = 1'b1; bus.upd_target = 32'h200;
    bus.upd_pred_taken = 1'b1; bus.upd_en = 1'b1;
    look_exp("same.before", 32'h80, 1'b0, 1'b0, 32'h84);
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
    model_update(32'h80, 1'b1, 32'h200, 1'b1);
    look_exp("same.after", 32'h80, 1'b1, 1'b1, 32'h200);

    // Reset on the same edge as an update drops the update.
    bus.upd_pc = 32'hC0; bus.upd_taken = 1'b1; bus.upd_en = 1'b1;
    do_reset();
    bus.upd_en = 1'b0;
    look_exp("rst.drop", 32'hC0, 1'b0, 1'b0, 32'hC4);
    chk_stats("rst.drop", 32'd0, 32'd0);

    for (int i = 0; i < 10; i++) begin
      logic tk;
      tk = 1'(i % 2);
      upd(32'h200 + 32'(i * 4), tk, 32'h1000, (i < 4) ? !tk : tk);
    end
    chk_stats("stats10", 32'd10, 32'd4);
    upd(32'h42, 1'b1, 32'h900, 1'b0);
    chk_stats("misalign", 32'd10, 32'd4);
    look_exp("misalign.40", 32'h40, 1'b0, 1'b0, 32'h44);
    look_exp("misalign.42", 32'h42, 1'b0, 1'b0, 32'h46);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, lpc, tg;
      logic tk, pr, en, r;
      pc  = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 2) |
            (($urandom % 8 == 0) ? $urandom_range(1, 3) : 0);
      lpc = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 2) |
            (($urandom % 8 == 0) ? $urandom_range(1, 3) : 0);
      tg = $urandom & 32'hFFFF_FFFC;
      tk = 1'($urandom % 2); pr = 1'($urandom % 2);
      en = ($urandom % 4 != 0);
      r  = ($urandom % 40 == 0);
      bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_target = tg;
      bus.upd_pred_taken = pr; bus.upd_en = en; rst = r;
      look_model($sformatf("rnd[%0d]", n), lpc);
      @(posedge clk);
      #1;
      if (r) model_reset();
      else if (en) model_update(pc, tk, tg, pr);
      rst = 1'b0; bus.upd_en = 1'b0;
      chk_stats($sformatf("rnd[%0d]", n), 32'(m_br), 32'(m_mp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
